// File: rtl/fetch_control.sv
// Instruction-fetch sequencer: owns the PC, drives a request/ready instruction
// memory, loads the IF/ID register and applies ID-stage stall and redirect.
module fetch_control #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic        i_jump,
    input  logic [31:0] i_jump_pc,
    input  logic        i_imem_ready,
    input  logic [31:0] i_imem_rdata,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    output logic [31:0] o_pc,
    output logic [31:0] o_if_id_instruction,
    output logic [31:0] o_if_id_pc4,
    output logic        o_if_id_valid,
    output logic [15:0] o_stall_cycles
);

    typedef enum logic [1:0] {S_BOOT, S_FETCH, S_DRAIN, S_HOLD} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] r_target;
    logic [31:0] r_hold;
    logic [31:0] r_instr;
    logic [31:0] r_pc4;
    logic        r_valid;
    logic [15:0] r_stall_cycles;
    logic [31:0] w_pc_plus4;
    logic        w_count_stall;

    assign w_pc_plus4    = r_pc + 32'd4;
    assign w_count_stall = i_stall && !i_jump && (r_state != S_BOOT);

    always_ff @(posedge i_clock) begin
        if (i_reset) r_state <= S_BOOT;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_BOOT:  w_state_next = S_FETCH;
            S_FETCH: begin
                if (i_imem_ready) begin
                    if (!i_jump && i_stall) w_state_next = S_HOLD;
                end else if (i_jump) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: if (i_imem_ready) w_state_next = S_FETCH;
            S_HOLD:  if (i_jump || !i_stall) w_state_next = S_FETCH;
            default: w_state_next = S_BOOT;
        endcase
    end

    always_comb begin
        o_imem_req = (r_state == S_FETCH);
    end

    assign o_imem_addr = r_pc;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_pc     <= RESET_PC;
            r_target <= 32'd0;
            r_hold   <= 32'd0;
            r_instr  <= 32'd0;
            r_pc4    <= 32'd0;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (i_imem_ready) begin
                        if (i_jump) begin
                            r_pc    <= i_jump_pc;
                            r_valid <= 1'b0;
                        end else if (i_stall) begin
                            r_hold  <= i_imem_rdata;
                        end else begin
                            r_instr <= i_imem_rdata;
                            r_pc4   <= w_pc_plus4;
                            r_valid <= 1'b1;
                            r_pc    <= w_pc_plus4;
                        end
                    end else if (i_jump) begin
                        r_target <= i_jump_pc;
                        r_valid  <= 1'b0;
                    end else if (!i_stall) begin
                        r_valid  <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    // The in-flight word belongs to the abandoned path; only its completion matters.
                    r_valid <= 1'b0;
                    if (i_jump) r_target <= i_jump_pc;
                    if (i_imem_ready) r_pc <= i_jump ? i_jump_pc : r_target;
                end
                S_HOLD: begin
                    if (i_jump) begin
                        r_pc    <= i_jump_pc;
                        r_valid <= 1'b0;
                    end else if (!i_stall) begin
                        r_instr <= r_hold;
                        r_pc4   <= w_pc_plus4;
                        r_valid <= 1'b1;
                        r_pc    <= w_pc_plus4;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset)
            r_stall_cycles <= 16'd0;
        else if (w_count_stall && r_stall_cycles != 16'hFFFF)
            r_stall_cycles <= r_stall_cycles + 16'd1;
    end

    assign o_pc                = r_pc;
    assign o_if_id_instruction = r_instr;
    assign o_if_id_pc4         = r_pc4;
    assign o_if_id_valid       = r_valid;
    assign o_stall_cycles      = r_stall_cycles;

endmodule

// File: tb/tb_fetch_control.sv
// Directed bench for fetch_control; memory returns {16'hC0DE, addr[15:0]}.
module tb_fetch_control;

    logic        clk = 1'b0;
    logic        reset, stall, jump, imem_ready;
    logic [31:0] jump_pc;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic [31:0] imem_addr, pc, if_id_instruction, if_id_pc4;
    logic        if_id_valid;
    logic [15:0] stall_cycles;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign imem_rdata = {16'hC0DE, imem_addr[15:0]};

    fetch_control #(.RESET_PC(32'h0000_0000)) dut (
        .i_clock             (clk),
        .i_reset             (reset),
        .i_stall             (stall),
        .i_jump              (jump),
        .i_jump_pc           (jump_pc),
        .i_imem_ready        (imem_ready),
        .i_imem_rdata        (imem_rdata),
        .o_imem_req          (imem_req),
        .o_imem_addr         (imem_addr),
        .o_pc                (pc),
        .o_if_id_instruction (if_id_instruction),
        .o_if_id_pc4         (if_id_pc4),
        .o_if_id_valid       (if_id_valid),
        .o_stall_cycles      (stall_cycles)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] ins, input logic [31:0] p4, input logic v);
        chk({tag, ".instr"}, if_id_instruction, ins);
        chk({tag, ".pc4"}, if_id_pc4, p4);
        chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, v});
    endtask

    task automatic drive(input logic rdy, input logic stl, input logic jmp, input logic [31:0] jpc);
        imem_ready = rdy;
        stall      = stl;
        jump       = jmp;
        jump_pc    = jpc;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        tick(); tick();
        // reset state
        chk("rst.pc", pc, 32'h0);
        chk_ifid("rst", 32'h0, 32'h0, 1'b0);
        chk("rst.stall_cycles", {16'd0, stall_cycles}, 32'h0);
        chk("rst.req", {31'd0, imem_req}, 32'h0);

        // zero-wait flow
        reset = 1'b0;
        tick();                                   // BOOT -> FETCH
        chk("boot.req", {31'd0, imem_req}, 32'h1);
        chk("boot.addr", imem_addr, 32'h0);
        chk_ifid("boot", 32'h0, 32'h0, 1'b0);
        tick();
        chk_ifid("zw0", 32'hC0DE_0000, 32'h4, 1'b1);
        chk("zw0.pc", pc, 32'h4);
        tick();
        chk_ifid("zw1", 32'hC0DE_0004, 32'h8, 1'b1);
        tick();
        chk_ifid("zw2", 32'hC0DE_0008, 32'hC, 1'b1);
        chk("zw2.addr", imem_addr, 32'hC);

        // wait states: ready on every third cycle
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        chk("ws0.valid", {31'd0, if_id_valid}, 32'h0);
        chk("ws0.addr", imem_addr, 32'hC);
        tick();
        chk("ws1.valid", {31'd0, if_id_valid}, 32'h0);
        chk("ws1.addr", imem_addr, 32'hC);
        chk("ws1.req", {31'd0, imem_req}, 32'h1);
        imem_ready = 1'b1;
        tick();
        chk_ifid("ws2", 32'hC0DE_000C, 32'h10, 1'b1);
        imem_ready = 1'b0;
        tick();
        chk("ws3.valid", {31'd0, if_id_valid}, 32'h0);
        chk("ws3.addr", imem_addr, 32'h10);
        tick();
        imem_ready = 1'b1;
        tick();
        chk_ifid("ws5", 32'hC0DE_0010, 32'h14, 1'b1);

        // load-use stall while word @0x8 returns
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick(); tick(); tick();                   // BOOT, @0, @4
        chk_ifid("lu.pre", 32'hC0DE_0004, 32'h8, 1'b1);
        stall = 1'b1;
        tick();
        chk_ifid("lu.s1", 32'hC0DE_0004, 32'h8, 1'b1);
        chk("lu.s1.req", {31'd0, imem_req}, 32'h0);
        chk("lu.s1.cnt", {16'd0, stall_cycles}, 32'd1);
        tick();
        chk_ifid("lu.s2", 32'hC0DE_0004, 32'h8, 1'b1);
        stall = 1'b0;
        tick();
        chk_ifid("lu.rel", 32'hC0DE_0008, 32'hC, 1'b1);
        chk("lu.cnt", {16'd0, stall_cycles}, 32'd2);
        chk("lu.pc", pc, 32'hC);

        // jump while access pending -> DRAIN, target applied on completion
        drive(1'b0, 1'b0, 1'b1, 32'h100);
        tick();
        chk("jp.valid", {31'd0, if_id_valid}, 32'h0);
        chk("jp.req", {31'd0, imem_req}, 32'h0);
        chk("jp.pc", pc, 32'hC);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        chk("jp.drain.valid", {31'd0, if_id_valid}, 32'h0);
        chk("jp.drain.cnt", {16'd0, stall_cycles}, 32'd3);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        chk("jp.addr", imem_addr, 32'h100);
        chk("jp.req2", {31'd0, imem_req}, 32'h1);
        chk("jp.valid2", {31'd0, if_id_valid}, 32'h0);
        tick();
        chk_ifid("jp.new", 32'hC0DE_0100, 32'h104, 1'b1);

        // jump with stall while in HOLD
        stall = 1'b1;
        tick();
        chk("hj.cnt0", {16'd0, stall_cycles}, 32'd4);
        drive(1'b1, 1'b1, 1'b1, 32'h40);
        tick();
        chk("hj.valid", {31'd0, if_id_valid}, 32'h0);
        chk("hj.pc", pc, 32'h40);
        chk("hj.addr", imem_addr, 32'h40);
        chk("hj.cnt", {16'd0, stall_cycles}, 32'd4);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        chk_ifid("hj.new", 32'hC0DE_0040, 32'h44, 1'b1);

        // jump in FETCH with ready discards the returned word
        drive(1'b1, 1'b0, 1'b1, 32'h200);
        tick();
        chk("fj.valid", {31'd0, if_id_valid}, 32'h0);
        chk("fj.pc", pc, 32'h200);

        // PC wrap
        drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        tick();
        chk("wr.pc0", pc, 32'hFFFF_FFFC);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        chk_ifid("wr", 32'hC0DE_FFFC, 32'h0, 1'b1);
        chk("wr.pc", pc, 32'h0);

        // DRAIN: later jump overwrites target
        drive(1'b0, 1'b0, 1'b1, 32'h300);
        tick();
        drive(1'b0, 1'b0, 1'b1, 32'h340);
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        chk("dr.ovr.addr", imem_addr, 32'h340);
        // DRAIN: jump in the completing cycle wins over stored target
        drive(1'b0, 1'b0, 1'b1, 32'h500);
        tick();
        drive(1'b1, 1'b0, 1'b1, 32'h580);
        tick();
        chk("dr.same.addr", imem_addr, 32'h580);
        chk("dr.same.valid", {31'd0, if_id_valid}, 32'h0);

        // stall counter saturation inside HOLD
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        repeat (70000) @(posedge clk);
        #1;
        chk("sat.cnt", {16'd0, stall_cycles}, 32'h0000_FFFF);
        chk("sat.req", {31'd0, imem_req}, 32'h0);

        // reset mid-HOLD, then BOOT does not count stall
        reset = 1'b1;
        tick();
        chk("rh.pc", pc, 32'h0);
        chk_ifid("rh", 32'h0, 32'h0, 1'b0);
        chk("rh.cnt", {16'd0, stall_cycles}, 32'h0);
        chk("rh.req", {31'd0, imem_req}, 32'h0);
        reset = 1'b0;
        tick();
        chk("bt.cnt", {16'd0, stall_cycles}, 32'h0);
        tick();
        chk("bt.cnt2", {16'd0, stall_cycles}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
